// File: rtl/lut_eval_pkg.sv
// Shared types and helpers for the LUT evaluator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lut_eval_pkg;

    localparam int N_IN_MAX = 6;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    // Number of truth-table entries for an n-input LUT; sizes beyond the
    // supported maximum are clamped so elaboration never explodes.
    function automatic int table_width(input int n);
        return (n > N_IN_MAX) ? (1 << N_IN_MAX) : (1 << n);
    endfunction

endpackage

// File: rtl/lut_skid_buf.sv
// Two-entry in-order result buffer with a 1-bit payload.
// Latency: a push is visible at dout (empty low) the cycle after it is sampled.
// Backpressure: full blocks new pushes; a pop only takes effect when not empty.
//
// Ports: clk, rst (sync, active-high); push/din write side; pop read side;
//        full/empty status; dout is the registered head entry.
module lut_skid_buf (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic dout
);

    logic [1:0] cnt_q;
    logic       head_q;
    logic       tail_q;
    logic       push_ok;
    logic       pop_ok;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign dout    = head_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            head_q <= 1'b0;
            tail_q <= 1'b0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= din;
                    else               tail_q <= din;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new entry lands behind whatever remains.
                    if (cnt_q == 2'd1) begin
                        head_q <= din;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lut_eval_pipe.sv
// Reprogrammable N_IN-input truth-table evaluator with a serial table reload port.
// Latency: result valid one cycle after the input handshake.
// Backpressure: in_ready drops when the 2-entry output buffer is full or a reload is in progress.
//
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data input stream;
//        out_valid/out_ready/out_data result stream; cfg_start/cfg_valid/cfg_din
//        serial reload (MSB first); cfg_busy/cfg_done reload status.
// Optional macro LUT_EVAL_READBACK_EN adds cfg_dout: the old table bit at the
// index being replaced, registered one cycle after each cfg_valid sample.
module lut_eval_pipe
    import lut_eval_pkg::*;
#(
    parameter int                             N_IN = 4,
    parameter logic [table_width(N_IN)-1:0]   INIT = 16'h4724
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_data,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_din,
    output logic            cfg_busy,
    output logic            cfg_done
`ifdef LUT_EVAL_READBACK_EN
    ,
    output logic            cfg_dout
`endif
);

    localparam int              W        = table_width(N_IN);
    localparam logic [N_IN:0]   CNT_FULL = {1'b1, {N_IN{1'b0}}};

    state_t          state_q;
    state_t          state_nxt;
    logic [W-1:0]    lut_q;
    logic [W-1:0]    shadow_q;
    logic [N_IN:0]   cnt_q;
    logic            load_done;
    logic            in_fire;
    logic            out_fire;
    logic            buf_full;
    logic            buf_empty;

    // The commit cycle is the LOAD cycle in which the counter already shows a full table.
    assign load_done = (state_q == LOAD) && (cnt_q == CNT_FULL);
    assign in_ready  = (state_q == RUN) && !buf_full;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = !buf_empty;
    assign out_fire  = out_valid && out_ready;
    assign cfg_busy  = (state_q == LOAD);
    assign cfg_done  = load_done;

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            RUN:     if (cfg_start) state_nxt = LOAD;
            LOAD:    if (load_done) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Table, shadow and counter. cfg_valid in RUN and cfg_start in LOAD fall through untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            lut_q    <= INIT;
            shadow_q <= '0;
            cnt_q    <= '0;
        end else if (state_q == RUN) begin
            if (cfg_start) begin
                shadow_q <= '0;
                cnt_q    <= '0;
            end
        end else if (load_done) begin
            lut_q <= shadow_q;
        end else if (cfg_valid) begin
            shadow_q <= {shadow_q[W-2:0], cfg_din};
            cnt_q    <= cnt_q + (N_IN+1)'(1);
        end
    end

`ifdef LUT_EVAL_READBACK_EN
    // Bit arriving at count c lands at index W-1-c, which is the bitwise inverse of c.
    logic [N_IN-1:0] rd_idx;
    assign rd_idx = ~cnt_q[N_IN-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_dout <= 1'b0;
        end else if ((state_q == LOAD) && !load_done && cfg_valid) begin
            cfg_dout <= lut_q[rd_idx];
        end
    end
`endif

    lut_skid_buf u_out_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (in_fire),
        .din   (lut_q[in_data]),
        .pop   (out_fire),
        .full  (buf_full),
        .empty (buf_empty),
        .dout  (out_data)
    );

endmodule

// File: tb/tb_lut_eval_pipe.sv
// Self-checking bench for lut_eval_pipe (N_IN=4, INIT=16'h4724).
// A queue-based model predicts the output stream; directed steps pin literal results.
// Define LUT_EVAL_READBACK_EN to also check the cfg_dout stream.
module tb_lut_eval_pipe;

    localparam logic [15:0] INIT_TT = 16'h4724;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_data;
    logic       cfg_start;
    logic       cfg_valid;
    logic       cfg_din;
    logic       cfg_busy;
    logic       cfg_done;
`ifdef LUT_EVAL_READBACK_EN
    logic       cfg_dout;
    logic [15:0] rb_word;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] model_lut = INIT_TT;
    bit          exp_busy = 0;
    bit          exp_done = 0;
    bit          q[$];
    bit          got[$];
    int          busy_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    lut_eval_pipe #(.N_IN(4), .INIT(16'h4724)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_din   (cfg_din),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done)
`ifdef LUT_EVAL_READBACK_EN
        ,
        .cfg_dout  (cfg_dout)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the table maps index to bit; accepted vectors queue their result in order.
    always @(posedge clk) begin
        bit fi;
        bit fo;
        if (rst) begin
            q.delete();
        end else begin
            fi = in_valid && !exp_busy && (q.size() < 2);
            fo = out_ready && (q.size() > 0);
            if (fo) begin
                got.push_back(out_data);
                void'(q.pop_front());
            end
            if (fi) q.push_back(model_lut[in_data]);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", 32'(out_valid), 32'(q.size() > 0));
            if (q.size() > 0) check("out_data", 32'(out_data), 32'(q[0]));
            check("in_ready", 32'(in_ready), 32'(!exp_busy && (q.size() < 2)));
            check("cfg_busy", 32'(cfg_busy), 32'(exp_busy));
            check("cfg_done", 32'(cfg_done), 32'(exp_done));
            if (cfg_busy === 1'b1) busy_cnt++;
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_din   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        model_lut = INIT_TT;
    endtask

    task automatic wait_accept(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: input not accepted within 60 cycles", name);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        wait_accept("send_timeout");
    endtask

    // Serial reload of nt, MSB first; smask bit s marks slot s as a stall.
    // stop_after >= 0 abandons the load after that many bits (caller resets).
    task automatic load(input logic [15:0] nt, input logic [31:0] smask,
                        input int stop_after, input bit offer);
        int n = 0;
        busy_cnt  = 0;
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        exp_busy  = 1'b1;
        if (offer) begin
            in_valid = 1'b1;
            in_data  = 4'h3;
        end
        for (int s = 0; s < 32 && n < 16; s++) begin
            cfg_valid = !smask[s];
            cfg_din   = nt[15-n];
            @(posedge clk);
            #1;
            if (cfg_valid) begin
`ifdef LUT_EVAL_READBACK_EN
                check("cfg_dout", 32'(cfg_dout), 32'(model_lut[15-n]));
                rb_word = {rb_word[14:0], cfg_dout};
`endif
                n++;
            end
            if (stop_after == n) begin
                cfg_valid = 1'b0;
                return;
            end
        end
        cfg_valid = 1'b0;
        exp_done  = 1'b1;
        @(posedge clk);
        #1;
        exp_done  = 1'b0;
        exp_busy  = 1'b0;
        model_lut = nt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_din   = 1'b0;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_cfg_busy",  32'(cfg_busy),  32'd0);
        check("rst_cfg_done",  32'(cfg_done),  32'd0);
        @(posedge clk);
        #1;

        // Back-to-back evaluation with INIT
        got.delete();
        send(4'h2);
        send(4'h3);
        send(4'hA);
        send(4'hE);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_count", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            check("b2b_0", 32'(got[0]), 32'd1);
            check("b2b_1", 32'(got[1]), 32'd0);
            check("b2b_2", 32'(got[2]), 32'd1);
            check("b2b_3", 32'(got[3]), 32'd1);
        end

        // Backpressure: two accepted, third waits, head held
        got.delete();
        out_ready = 1'b0;
        send(4'h2);
        send(4'h3);
        in_valid = 1'b1;
        in_data  = 4'h5;
        repeat (3) @(negedge clk);
        check("bp_in_ready",  32'(in_ready),  32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_out_data",  32'(out_data),  32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept("bp_third_timeout");
        repeat (4) @(posedge clk);
        #1;
        check("bp_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            check("bp_0", 32'(got[0]), 32'd1);
            check("bp_1", 32'(got[1]), 32'd0);
            check("bp_2", 32'(got[2]), 32'd1);
        end

        // Reload all-ones with three stalls
        got.delete();
        load(16'hFFFF, 32'h0000_1084, -1, 1'b0);
        check("reload_busy_cycles", 32'(busy_cnt), 32'd20);
        send(4'h3);
        repeat (3) @(posedge clk);
        #1;
        check("reload_count", 32'(got.size()), 32'd1);
        if (got.size() == 1) check("reload_new_tt", 32'(got[0]), 32'd1);

        // Old result drains across a reload; input blocked while busy
        got.delete();
        out_ready = 1'b0;
        send(4'h3);
        out_ready = 1'b1;
        load(16'h0000, 32'h0, -1, 1'b1);
        check("drain_busy_cycles", 32'(busy_cnt), 32'd17);
        wait_accept("drain_accept_timeout");
        repeat (3) @(posedge clk);
        #1;
        check("drain_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            check("drain_old", 32'(got[0]), 32'd1);
            check("drain_new", 32'(got[1]), 32'd0);
        end

        // Reset in the middle of a load restores INIT
        got.delete();
        load(16'hAAAA, 32'h0, 7, 1'b0);
        do_reset();
        @(negedge clk);
        check("midrst_cfg_busy",  32'(cfg_busy),  32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        got.delete();
        send(4'h5);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_count", 32'(got.size()), 32'd1);
        if (got.size() == 1) check("midrst_init_5", 32'(got[0]), 32'd1);

`ifdef LUT_EVAL_READBACK_EN
        // Readback during a reload from INIT streams the old table MSB first
        rb_word = 16'h0;
        load(INIT_TT, 32'h0, -1, 1'b0);
        check("readback_stream", 32'(rb_word), 32'h4724);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
